// File: rtl/ahblite_fb_clear.sv
// ahblite_fb_clear -- AHB-Lite controlled sweep engine that fills up to NUM_CH
// image RAMs with a programmable word, one address per cycle.
//
// Build option: define FBCLR_AUTO_ON_RESET_EN to launch an all-channel,
// zero-fill sweep in the first cycle after HRESETn is released. Without it
// the block idles after reset until the CPU writes START.
//
// Bus handshake: an address phase is accepted when HSEL & HREADY & HTRANS[1].
// The slave never stalls (HREADYOUT=1, HRESP=OKAY), so every accepted transfer
// has its data phase in the next cycle; writes commit on the edge closing
// that data phase and reads are driven combinationally during it.
//
// Register map (HADDR[3:2]):
//   0x0 CTRL    W: bit0 START, bit1 ABORT, [8+NUM_CH-1:8] MASK; R: MASK only
//   0x4 FILL    [DATA_WIDTH-1:0] fill word
//   0x8 STATUS  bit0 BUSY, bit1 DONE (sticky, write 1 to clear)
//   0xC CURADDR sweep counter, read-only
//
// DBG_STATE exposes the FSM state (0 idle, 1 sweeping) for checkers.
// DATA_WIDTH must be 1..32 and NUM_CH 1..16 so every register fits one word.
module ahblite_fb_clear #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8,
  parameter int NUM_CH     = 2
) (
  input  logic                  HCLK,
  input  logic                  HRESETn,
  input  logic                  HSEL,
  input  logic                  HREADY,
  input  logic                  HWRITE,
  input  logic [1:0]            HTRANS,
  input  logic [31:0]           HADDR,
  input  logic [2:0]            HSIZE,
  input  logic [31:0]           HWDATA,
  output logic [31:0]           HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [NUM_CH-1:0]     RAM_WE,
  output logic [ADDR_WIDTH-1:0] RAM_ADDR,
  output logic [DATA_WIDTH-1:0] RAM_WDATA,
  output logic                  BUSY,
  output logic                  DONE_IRQ,
  output logic                  DBG_STATE
);

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_FILL    = 2'd1;
  localparam logic [1:0] REG_STATUS  = 2'd2;
  localparam logic [ADDR_WIDTH-1:0] CNT_LAST = '1;

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_SWEEP = 1'b1
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  r_ap_valid;
  logic                  r_ap_write;
  logic [1:0]            r_ap_reg;
  logic [NUM_CH-1:0]     r_mask;
  logic [DATA_WIDTH-1:0] r_fill;
  logic                  r_done;
  logic                  r_irq;
  logic [ADDR_WIDTH-1:0] r_cnt;
  logic [NUM_CH-1:0]     r_mask_sh;
  logic [DATA_WIDTH-1:0] r_fill_sh;

  logic                  w_wr;
  logic                  w_wr_ctrl;
  logic                  w_wr_fill;
  logic                  w_wr_status;
  logic                  w_bus_start;
  logic                  w_abort;
  logic [NUM_CH-1:0]     w_wr_mask;
  logic                  w_auto;
  logic                  w_start_req;
  logic [NUM_CH-1:0]     w_start_mask;
  logic [DATA_WIDTH-1:0] w_start_fill;
  logic                  w_launch;
  logic                  w_empty;
  logic                  w_finish;
  logic                  w_step;
  logic                  w_set_done;
  logic [31:0]           w_rd;
  logic                  w_unused_ok;

  // HSIZE, the upper address bits and the unused write-data bits carry no meaning here.
  assign w_unused_ok = &{1'b0, HSIZE, HADDR, HWDATA};

  assign HREADYOUT = 1'b1;
  assign HRESP     = 1'b0;
  assign DONE_IRQ  = r_irq;
  assign DBG_STATE = r_state;

  // Capture an accepted address phase for use in the following data phase.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_ap_valid <= 1'b0;
      r_ap_write <= 1'b0;
      r_ap_reg   <= 2'd0;
    end else if (HREADY) begin
      r_ap_valid <= HSEL & HTRANS[1];
      r_ap_write <= HWRITE;
      r_ap_reg   <= HADDR[3:2];
    end
  end

  // Data-phase write decode.
  assign w_wr        = r_ap_valid & r_ap_write;
  assign w_wr_ctrl   = w_wr & (r_ap_reg == REG_CTRL);
  assign w_wr_fill   = w_wr & (r_ap_reg == REG_FILL);
  assign w_wr_status = w_wr & (r_ap_reg == REG_STATUS);
  assign w_bus_start = w_wr_ctrl & HWDATA[0];
  assign w_abort     = w_wr_ctrl & HWDATA[1];
  assign w_wr_mask   = HWDATA[8 +: NUM_CH];

`ifdef FBCLR_AUTO_ON_RESET_EN
  logic r_auto_pend;

  // High only in the first cycle after reset is released: acts as a START.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) r_auto_pend <= 1'b1;
    else          r_auto_pend <= 1'b0;
  end

  assign w_auto = r_auto_pend;
`else
  assign w_auto = 1'b0;
`endif

  // The automatic launch takes precedence over any bus START in that cycle.
  assign w_start_req  = w_auto | w_bus_start;
  assign w_start_mask = w_auto ? {NUM_CH{1'b1}} : w_wr_mask;
  assign w_start_fill = w_auto ? {DATA_WIDTH{1'b0}} : r_fill;

  // FSM state register.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) r_state <= S_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next state plus the one-cycle events that steer the datapath.
  always_comb begin
    w_state_nxt = r_state;
    w_launch    = 1'b0;
    w_empty     = 1'b0;
    w_finish    = 1'b0;
    w_step      = 1'b0;
    case (r_state)
      S_IDLE: begin
        // ABORT beats START; an empty mask completes without writing.
        if (w_start_req && !w_abort) begin
          if (w_start_mask != '0) begin
            w_state_nxt = S_SWEEP;
            w_launch    = 1'b1;
          end else begin
            w_empty = 1'b1;
          end
        end
      end
      S_SWEEP: begin
        if (w_abort) begin
          w_state_nxt = S_IDLE;
        end else if (r_cnt == CNT_LAST) begin
          w_state_nxt = S_IDLE;
          w_finish    = 1'b1;
        end else begin
          w_step = 1'b1;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_set_done = w_empty | w_finish;

  // FSM outputs: RAM port is quiet (all zero) outside a sweep.
  always_comb begin
    RAM_WE    = '0;
    RAM_ADDR  = '0;
    RAM_WDATA = '0;
    BUSY      = 1'b0;
    if (r_state == S_SWEEP) begin
      RAM_WE    = r_mask_sh;
      RAM_ADDR  = r_cnt;
      RAM_WDATA = r_fill_sh;
      BUSY      = 1'b1;
    end
  end

  // Sweep counter and the shadow copies that freeze MASK/FILL for the sweep.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_cnt     <= '0;
      r_mask_sh <= '0;
      r_fill_sh <= '0;
    end else if (w_launch) begin
      r_cnt     <= '0;
      r_mask_sh <= w_start_mask;
      r_fill_sh <= w_start_fill;
    end else if (w_step) begin
      r_cnt <= r_cnt + ADDR_WIDTH'(1);
    end
  end

  // Software-visible MASK and FILL registers; writable at any time.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_mask <= '1;
      r_fill <= '0;
    end else begin
      if (w_wr_ctrl) r_mask <= w_wr_mask;
      if (w_wr_fill) r_fill <= HWDATA[DATA_WIDTH-1:0];
    end
  end

  // Sticky DONE flag and its one-cycle interrupt pulse; completion beats a clear.
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      r_done <= 1'b0;
      r_irq  <= 1'b0;
    end else begin
      r_irq <= w_set_done;
      if (w_set_done)                     r_done <= 1'b1;
      else if (w_launch)                  r_done <= 1'b0;
      else if (w_wr_status && HWDATA[1])  r_done <= 1'b0;
    end
  end

  // Read mux for the register addressed by the current data phase.
  always_comb begin
    w_rd = '0;
    case (r_ap_reg)
      REG_CTRL:   w_rd[8 +: NUM_CH] = r_mask;
      REG_FILL:   w_rd[DATA_WIDTH-1:0] = r_fill;
      REG_STATUS: begin
        w_rd[0] = (r_state == S_SWEEP);
        w_rd[1] = r_done;
      end
      default:    w_rd[ADDR_WIDTH-1:0] = r_cnt;
    endcase
  end

  assign HRDATA = (r_ap_valid && !r_ap_write) ? w_rd : 32'h0;

endmodule

// File: doc/ahblite_fb_clear.md
# ahblite_fb_clear

AHB-Lite hardware sweep engine that fills up to NUM_CH VGA image RAMs with a programmable value, one word per cycle. It sits beside the AHBVGA instances in AHBLITE_SYS and drives a dedicated write port on each image RAM. It replaces bench-side backdoor clearing of the image buffers with a bus-visible, CPU-controlled operation.

## Interface
- ADDR_WIDTH, 13: image RAM address width; a sweep covers 0..2^ADDR_WIDTH-1.
- DATA_WIDTH, 8: image RAM word width; must be 1..32.
- NUM_CH, 2: number of image RAM channels; must be 1..16.
- HCLK  in  1  system clock; all state on rising edge.
- HRESETn  in  1  synchronous, active-low reset; sampled on HCLK rising edge.
- HSEL, HREADY, HWRITE  in  1  AHB-Lite slave select, bus ready, write.
- HTRANS  in  2  AHB-Lite transfer type; only NONSEQ/SEQ (bit1=1) act.
- HADDR  in  32  address; bits[3:2] select the register.
- HSIZE  in  3  ignored; all accesses are treated as word.
- HWDATA  in  32  write data, data phase.
- HRDATA  out  32  read data.
- HREADYOUT  out  1  constant 1 (zero wait state).
- HRESP  out  1  constant 0.
- RAM_WE  out  NUM_CH  per-channel write enable.
- RAM_ADDR  out  ADDR_WIDTH  shared write address.
- RAM_WDATA  out  DATA_WIDTH  shared write data.
- BUSY  out  1  sweep in progress.
- DONE_IRQ  out  1  one-cycle pulse on sweep completion.

## Operation
- Registers, word offsets: 0x0 CTRL (W: bit0 START, bit1 ABORT, bits[8+NUM_CH-1:8] MASK; R: MASK plus zeros in bits 0-1); 0x4 FILL [DATA_WIDTH-1:0] R/W; 0x8 STATUS (bit0 BUSY, bit1 DONE sticky, write 1 to bit1 clears it); 0xC CURADDR, read-only.
- Address phase is registered when HSEL & HREADY & HTRANS[1]. Writes take effect at the end of the data phase. Reads return the register value as of the data phase.
- FSM states:
  - IDLE -> SWEEP: START=1 with MASK!=0 (the written value). Latches MASK and FILL into shadows, sets the counter to 0, and clears DONE.
  - IDLE with START=1 and MASK=0: no writes; DONE set and DONE_IRQ pulses the next cycle.
  - SWEEP: each cycle drives RAM_WE=shadow MASK, RAM_ADDR=counter, and RAM_WDATA=shadow FILL, then increments the counter.
  - SWEEP -> IDLE after the write at counter=2^ADDR_WIDTH-1: sets DONE and pulses DONE_IRQ in the following cycle. The counter does not wrap past the last address.
  - SWEEP -> IDLE on ABORT: no further RAM_WE, DONE is not set, and CURADDR holds the last address written.
- START while in SWEEP is ignored. START and ABORT written together from IDLE: ABORT wins and nothing starts.
- FILL and MASK writes during SWEEP update the registers but not the active sweep.
- CURADDR = counter, zero-extended.

## Timing
- Reset (HRESETn=0 at an edge) sets:
  - outputs: RAM_WE=0, RAM_ADDR=0, RAM_WDATA=0, BUSY=0, DONE_IRQ=0, HRDATA=0;
  - registers: MASK=all ones, FILL=0, DONE=0, counter=0.
- Reset mid-sweep stops writes at that edge.
- START data phase in cycle N:
  - first RAM_WE in cycle N+1 (address 0);
  - last write in cycle N+2^ADDR_WIDTH;
  - BUSY high from N+1 through N+2^ADDR_WIDTH;
  - DONE_IRQ high and DONE=1 in cycle N+2^ADDR_WIDTH+1.
- ABORT data phase in cycle M: no RAM_WE from cycle M+1 onward, and BUSY=0 in M+1.
- Throughput: one word per cycle per enabled channel. Sweep length is 2^ADDR_WIDTH cycles.

## Configuration
- FBCLR_AUTO_ON_RESET_EN defined: the first cycle after HRESETn returns high starts a sweep with MASK=all ones and FILL=0, with identical timing. DONE is set at the end of that sweep. Bus START is ignored until that sweep ends. ABORT still works.
- Undefined: the block stays IDLE after reset until a bus START.

## Test plan
- ADDR_WIDTH=4, NUM_CH=2: write FILL=0xA5, then CTRL=0x301 -> 16 consecutive cycles with RAM_WE=2'b11 and RAM_ADDR 0..15, RAM_WDATA=0xA5; then DONE_IRQ pulses once and STATUS reads 0x2.
- CTRL=0x201 -> RAM_WE=2'b10 only. Write FILL=0x11 mid-sweep -> RAM_WDATA stays at the old value. Write 1 to STATUS bit1 afterwards -> DONE reads 0.
- ABORT at the 6th write -> CURADDR reads 5, no further RAM_WE, DONE=0, no DONE_IRQ.
- CTRL=0x001 (MASK=0) -> zero RAM_WE cycles and DONE_IRQ the next cycle. CTRL=0x303 from IDLE -> nothing starts.
- HRESETn=0 for one edge in mid-sweep -> all outputs at reset values next cycle; MASK reads 0x300.
- With FBCLR_AUTO_ON_RESET_EN: after reset release, 16 writes of 0x00 to both channels with no bus access. A START issued mid-sweep is ignored.
